etapa_id_ex: RTL and testbench
==============================

ETAPA_ID_EX -- requirements
Module: etapa_id_ex

Interface
REQ-001 Parameter: VEC_W, default 128, width of one vector operand.
REQ-002 Parameter: DATA_W, default 32, width of the scalar operand.
REQ-003 Parameter: ADDR_W, default 3, register-address width.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-high.
REQ-006 id_valid  in  1  the decode stage presents an instruction.
REQ-007 id_ready  out  1  the stage accepts the instruction this cycle.
REQ-008 id_opcode  in  4  decoded opcode.
REQ-009 id_ctrl  in  13  control bundle, MSB..LSB: reg_rdv, reg_rds, sel_dest, sel_op, sel_ad, sel_int, sum_mem, sel_mem, sel_data, mem_wr, sel_wb, reg_wrv, reg_wrs.
REQ-010 id_src_a, id_src_b  in  ADDR_W each  source vector register addresses.
REQ-011 id_dest  in  ADDR_W  destination register address.
REQ-012 id_vdata_a, id_vdata_b  in  VEC_W each  vector operands.
REQ-013 id_sdata  in  DATA_W  scalar operand.
REQ-014 flush  in  1  synchronous pipeline flush.
REQ-015 ex_ready  in  1  execute stage accepts the held instruction.
REQ-016 ex_valid  out  1  held instruction is valid.
REQ-017 ex_opcode, ex_ctrl, ex_dest, ex_vdata_a, ex_vdata_b, ex_sdata  out  same widths as the id_ counterparts  registered copies.
REQ-018 hazard  out  1  load-use hazard detected this cycle (combinational).
REQ-019 bubble_count  out  8  number of inserted bubbles, saturating.

Function
REQ-020 The FSM SHALL have three states: IDLE (empty), HOLD (one valid instruction), BUBBLE (forced empty cycle).
REQ-021 ex_valid SHALL be 1 only in HOLD.
REQ-022 The held instruction is a load when ex_ctrl sel_mem=1, mem_wr=0, and reg_wrv=1.
REQ-023 hazard SHALL be 1 when all of the following hold: state is HOLD; the held instruction is a load; id_valid=1; id_ctrl reg_rdv=1; ex_dest equals id_src_a or id_src_b.
REQ-024 id_ready SHALL be 0 when flush=1 or hazard=1.
REQ-025 Otherwise, id_ready SHALL be 1 in IDLE and BUBBLE, and equal to ex_ready in HOLD.
REQ-026 Transfer in (id_fire) occurs when id_valid=1 and id_ready=1; transfer out occurs when state is HOLD and ex_ready=1.
REQ-027 On id_fire, all id_ fields SHALL be captured into the ex_ registers; the next state is HOLD.
REQ-028 In HOLD without transfer out, every ex_ output SHALL hold its value; the registers SHALL not change.
REQ-029 HOLD with transfer out and no id_fire: if hazard=1, the next state is BUBBLE; otherwise it is IDLE.
REQ-030 Entry into BUBBLE SHALL increment bubble_count, which saturates at 255.
REQ-031 BUBBLE SHALL last exactly one cycle; the next state is HOLD on id_fire, otherwise IDLE.
REQ-032 In HOLD with hazard=1 and ex_ready=0, the state SHALL remain HOLD and the decode instruction SHALL not be accepted.
REQ-033 flush=1 SHALL take priority over every other event; the next state is IDLE and the held instruction is discarded.
REQ-034 A flush SHALL cause no bubble increment; the ex_ data registers MAY retain their values, but ex_valid SHALL be 0.
REQ-035 Latency is one cycle from id_fire to ex_valid=1, and two cycles when a bubble is inserted.
REQ-036 Throughput is one instruction per cycle when there is no hazard and ex_ready=1.
REQ-037 The data operands SHALL be passed through without modification; no arithmetic is performed.

Reset
REQ-038 While rst=1, the state SHALL be IDLE.
REQ-039 While rst=1, ex_valid, ex_opcode, ex_ctrl, ex_dest, ex_vdata_a, ex_vdata_b, ex_sdata, and bubble_count SHALL all be 0.
REQ-040 While rst=1, id_ready SHALL be 0.
REQ-041 Reset mid-operation SHALL discard the held instruction immediately, without waiting for a clock edge.
REQ-042 id_ready SHALL return to 1 in the first cycle after rst is released.

Verification
REQ-043 Streaming: opcodes 0000, 0001, 0010 on consecutive cycles with ex_ready=1 -> each appears on ex_opcode one cycle later; ex_valid stays 1; bubble_count stays 0.
REQ-044 Load-use: hold load 0011 with ex_dest=2, then present id_src_a=2, reg_rdv=1, ex_ready=1 -> hazard=1 and id_ready=0 for one cycle; next cycle ex_valid=0 (BUBBLE); the dependent instruction then appears; bubble_count=1.
REQ-045 Backpressure: ex_ready=0 for 3 cycles while holding opcode 0101 -> ex_ outputs stay stable and id_ready=0; on release, the next instruction follows in one cycle.
REQ-046 Flush: flush=1 in HOLD with id_valid=1 -> id_ready=0; next cycle ex_valid=0, the state is IDLE, and the incoming instruction is not captured.
REQ-047 Saturation: force 260 load-use bubbles -> bubble_count=255.
REQ-048 Asynchronous reset: assert rst mid-cycle while in HOLD -> ex_valid=0 and all ex_ outputs are 0 before the next clock edge.

Source files
------------

// File: rtl/etapa_id_ex.sv
// ID/EX pipeline register for a vector datapath: valid/ready handshake,
// load-use hazard detection with one-cycle bubble insertion, and flush.
module etapa_id_ex #(
  parameter int unsigned VEC_W  = 128,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [3:0]        id_opcode,
  input  logic [12:0]       id_ctrl,
  input  logic [ADDR_W-1:0] id_src_a,
  input  logic [ADDR_W-1:0] id_src_b,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic [VEC_W-1:0]  id_vdata_a,
  input  logic [VEC_W-1:0]  id_vdata_b,
  input  logic [DATA_W-1:0] id_sdata,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [3:0]        ex_opcode,
  output logic [12:0]       ex_ctrl,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [VEC_W-1:0]  ex_vdata_a,
  output logic [VEC_W-1:0]  ex_vdata_b,
  output logic [DATA_W-1:0] ex_sdata,
  output logic              hazard,
  output logic [7:0]        bubble_count
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned CTRL_W = 13;
  localparam int unsigned CNT_W  = 8;

  // Control bundle bit positions used by the hazard logic
  localparam int unsigned C_REG_RDV = 12;
  localparam int unsigned C_SEL_MEM = 5;
  localparam int unsigned C_MEM_WR  = 3;
  localparam int unsigned C_REG_WRV = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     ex_opcode_q, ex_opcode_d;
  logic [CTRL_W-1:0]   ex_ctrl_q, ex_ctrl_d;
  logic [ADDR_W-1:0]   ex_dest_q, ex_dest_d;
  logic [VEC_W-1:0]    ex_vdata_a_q, ex_vdata_a_d;
  logic [VEC_W-1:0]    ex_vdata_b_q, ex_vdata_b_d;
  logic [DATA_W-1:0]   ex_sdata_q, ex_sdata_d;
  logic [CNT_W-1:0]    bubble_count_q, bubble_count_d;

  logic held_is_load;
  logic src_match;
  logic hazard_c;
  logic id_ready_c;
  logic id_fire;
  logic xfer_out;

  // Hazard detection and handshake
  always_comb begin
    held_is_load = ex_ctrl_q[C_SEL_MEM] & ~ex_ctrl_q[C_MEM_WR] & ex_ctrl_q[C_REG_WRV];
    src_match    = (ex_dest_q == id_src_a) | (ex_dest_q == id_src_b);
    hazard_c     = (state_q == HOLD) & held_is_load & id_valid
                   & id_ctrl[C_REG_RDV] & src_match;
    id_ready_c   = 1'b0;
    if (!rst && !flush && !hazard_c) begin
      case (state_q)
        HOLD:    id_ready_c = ex_ready;
        default: id_ready_c = 1'b1;
      endcase
    end
    id_fire  = id_valid & id_ready_c;
    xfer_out = (state_q == HOLD) & ex_ready;
  end

  // Next-state and register update
  always_comb begin
    state_d        = state_q;
    ex_opcode_d    = ex_opcode_q;
    ex_ctrl_d      = ex_ctrl_q;
    ex_dest_d      = ex_dest_q;
    ex_vdata_a_d   = ex_vdata_a_q;
    ex_vdata_b_d   = ex_vdata_b_q;
    ex_sdata_d     = ex_sdata_q;
    bubble_count_d = bubble_count_q;

    if (flush) begin
      state_d = IDLE;
    end else if (id_fire) begin
      state_d      = HOLD;
      ex_opcode_d  = id_opcode;
      ex_ctrl_d    = id_ctrl;
      ex_dest_d    = id_dest;
      ex_vdata_a_d = id_vdata_a;
      ex_vdata_b_d = id_vdata_b;
      ex_sdata_d   = id_sdata;
    end else begin
      case (state_q)
        HOLD: begin
          if (xfer_out) begin
            if (hazard_c) begin
              state_d = BUBBLE;
              if (bubble_count_q != {CNT_W{1'b1}}) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
              end
            end else begin
              state_d = IDLE;
            end
          end
        end
        BUBBLE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ex_opcode_q    <= '0;
      ex_ctrl_q      <= '0;
      ex_dest_q      <= '0;
      ex_vdata_a_q   <= '0;
      ex_vdata_b_q   <= '0;
      ex_sdata_q     <= '0;
      bubble_count_q <= '0;
    end else begin
      state_q        <= state_d;
      ex_opcode_q    <= ex_opcode_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_dest_q      <= ex_dest_d;
      ex_vdata_a_q   <= ex_vdata_a_d;
      ex_vdata_b_q   <= ex_vdata_b_d;
      ex_sdata_q     <= ex_sdata_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign id_ready     = id_ready_c;
  assign hazard       = hazard_c;
  assign ex_valid     = (state_q == HOLD);
  assign ex_opcode    = ex_opcode_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign ex_dest      = ex_dest_q;
  assign ex_vdata_a   = ex_vdata_a_q;
  assign ex_vdata_b   = ex_vdata_b_q;
  assign ex_sdata     = ex_sdata_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_etapa_id_ex.sv
// Directed bench for etapa_id_ex: streaming, load-use bubble, backpressure,
// flush, counter saturation and asynchronous reset.
module tb_etapa_id_ex;

  localparam int unsigned VEC_W  = 128;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic [12:0] C_ALU   = 13'h0002;
  localparam logic [12:0] C_LOAD  = 13'h0022;
  localparam logic [12:0] C_STORE = 13'h002A;
  localparam logic [12:0] C_DEP   = 13'h1002;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic              id_ready;
  logic [3:0]        id_opcode;
  logic [12:0]       id_ctrl;
  logic [ADDR_W-1:0] id_src_a, id_src_b, id_dest;
  logic [VEC_W-1:0]  id_vdata_a, id_vdata_b;
  logic [DATA_W-1:0] id_sdata;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [3:0]        ex_opcode;
  logic [12:0]       ex_ctrl;
  logic [ADDR_W-1:0] ex_dest;
  logic [VEC_W-1:0]  ex_vdata_a, ex_vdata_b;
  logic [DATA_W-1:0] ex_sdata;
  logic              hazard;
  logic [7:0]        bubble_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  etapa_id_ex #(.VEC_W(VEC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_ctrl(id_ctrl),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_dest(id_dest),
    .id_vdata_a(id_vdata_a), .id_vdata_b(id_vdata_b), .id_sdata(id_sdata),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_ctrl(ex_ctrl),
    .ex_dest(ex_dest), .ex_vdata_a(ex_vdata_a), .ex_vdata_b(ex_vdata_b),
    .ex_sdata(ex_sdata), .hazard(hazard), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [12:0] ctrl,
                         input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] sb,
                         input logic [ADDR_W-1:0] d, input logic [VEC_W-1:0] va,
                         input logic [VEC_W-1:0] vb, input logic [DATA_W-1:0] sd);
    id_valid   = 1'b1;
    id_opcode  = op;
    id_ctrl    = ctrl;
    id_src_a   = sa;
    id_src_b   = sb;
    id_dest    = d;
    id_vdata_a = va;
    id_vdata_b = vb;
    id_sdata   = sd;
  endtask

  // One load followed by a dependent read of its destination, ex_ready high
  task automatic load_use_bubble();
    present(4'h3, C_LOAD, 3'd0, 3'd0, 3'd2, '0, '0, '0);
    tick();
    present(4'h4, C_DEP, 3'd2, 3'd5, 3'd3, '0, '0, '0);
    tick();
    id_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    present(4'hF, C_ALU, 3'd0, 3'd0, 3'd1, '1, '1, '1);
    #3;
    chk("rst_ex_valid", VEC_W'(ex_valid), 0);
    chk("rst_id_ready", VEC_W'(id_ready), 0);
    chk("rst_ex_opcode", VEC_W'(ex_opcode), 0);
    chk("rst_bubble", VEC_W'(bubble_count), 0);
    chk("rst_vdata_a", ex_vdata_a, 0);
    id_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_id_ready", VEC_W'(id_ready), 1);

    // Streaming: 0,1,2 back to back
    present(4'h0, C_ALU, 3'd1, 3'd1, 3'd1, 128'hA0, 128'hB0, 32'hC0);
    tick();
    present(4'h1, C_ALU, 3'd1, 3'd1, 3'd1, 128'hA1, 128'hB1, 32'hC1);
    #1;
    chk("str0_valid", VEC_W'(ex_valid), 1);
    chk("str0_opcode", VEC_W'(ex_opcode), 4'h0);
    chk("str0_id_ready", VEC_W'(id_ready), 1);
    tick();
    present(4'h2, C_ALU, 3'd1, 3'd1, 3'd4, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
            128'hB2, 32'h1234_5678);
    #1;
    chk("str1_valid", VEC_W'(ex_valid), 1);
    chk("str1_opcode", VEC_W'(ex_opcode), 4'h1);
    tick();
    id_valid = 1'b0;
    #1;
    chk("str2_valid", VEC_W'(ex_valid), 1);
    chk("str2_opcode", VEC_W'(ex_opcode), 4'h2);
    chk("str2_vdata_a", ex_vdata_a, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    chk("str2_vdata_b", ex_vdata_b, 128'hB2);
    chk("str2_sdata", VEC_W'(ex_sdata), 32'h1234_5678);
    chk("str2_dest", VEC_W'(ex_dest), 3'd4);
    chk("str2_bubble", VEC_W'(bubble_count), 0);
    tick();
    chk("str_drain_valid", VEC_W'(ex_valid), 0);

    // Load-use with ex_ready high: one bubble
    present(4'h3, C_LOAD, 3'd0, 3'd0, 3'd2, '0, '0, '0);
    tick();
    present(4'h4, C_DEP, 3'd2, 3'd5, 3'd3, 128'h44, 128'h55, 32'h66);
    #1;
    chk("lu_hazard", VEC_W'(hazard), 1);
    chk("lu_id_ready", VEC_W'(id_ready), 0);
    chk("lu_held_op", VEC_W'(ex_opcode), 4'h3);
    tick();
    chk("lu_bubble_valid", VEC_W'(ex_valid), 0);
    chk("lu_bubble_cnt", VEC_W'(bubble_count), 1);
    chk("lu_bubble_hazard", VEC_W'(hazard), 0);
    chk("lu_bubble_ready", VEC_W'(id_ready), 1);
    tick();
    id_valid = 1'b0;
    chk("lu_dep_valid", VEC_W'(ex_valid), 1);
    chk("lu_dep_op", VEC_W'(ex_opcode), 4'h4);
    chk("lu_dep_vdata_a", ex_vdata_a, 128'h44);
    tick();

    // Held store is not a load: no hazard
    present(4'h6, C_STORE, 3'd0, 3'd0, 3'd2, '0, '0, '0);
    tick();
    present(4'h7, C_DEP, 3'd6, 3'd2, 3'd3, '0, '0, '0);
    #1;
    chk("st_no_hazard", VEC_W'(hazard), 0);
    chk("st_id_ready", VEC_W'(id_ready), 1);
    tick();
    id_valid = 1'b0;
    chk("st_next_op", VEC_W'(ex_opcode), 4'h7);
    chk("st_bubble", VEC_W'(bubble_count), 1);
    tick();

    // Hazard while ex_ready low: stay in HOLD, then bubble on release
    present(4'h3, C_LOAD, 3'd0, 3'd0, 3'd4, '0, '0, '0);
    tick();
    present(4'h9, C_DEP, 3'd1, 3'd4, 3'd5, '0, '0, '0);
    ex_ready = 1'b0;
    #1;
    chk("hz_stall_hazard", VEC_W'(hazard), 1);
    chk("hz_stall_ready", VEC_W'(id_ready), 0);
    tick();
    chk("hz_stall_valid", VEC_W'(ex_valid), 1);
    chk("hz_stall_op", VEC_W'(ex_opcode), 4'h3);
    chk("hz_stall_cnt", VEC_W'(bubble_count), 1);
    ex_ready = 1'b1;
    tick();
    chk("hz_rel_bubble", VEC_W'(ex_valid), 0);
    chk("hz_rel_cnt", VEC_W'(bubble_count), 2);
    tick();
    id_valid = 1'b0;
    chk("hz_rel_dep", VEC_W'(ex_opcode), 4'h9);
    tick();

    // Backpressure: hold opcode 5 for three cycles
    present(4'h5, C_ALU, 3'd0, 3'd0, 3'd6, 128'h5A5A, 128'hA5A5, 32'h55);
    tick();
    ex_ready = 1'b0;
    present(4'h8, C_ALU, 3'd0, 3'd0, 3'd7, 128'h8, 128'h8, 32'h8);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_op", VEC_W'(ex_opcode), 4'h5);
      chk("bp_vdata_a", ex_vdata_a, 128'h5A5A);
      chk("bp_dest", VEC_W'(ex_dest), 3'd6);
      chk("bp_id_ready", VEC_W'(id_ready), 0);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_rel_ready", VEC_W'(id_ready), 1);
    tick();
    id_valid = 1'b0;
    chk("bp_next_op", VEC_W'(ex_opcode), 4'h8);
    chk("bp_next_valid", VEC_W'(ex_valid), 1);
    tick();

    // Flush while holding, with a new instruction offered
    present(4'h9, C_ALU, 3'd0, 3'd0, 3'd1, '0, '0, '0);
    tick();
    present(4'hA, C_ALU, 3'd0, 3'd0, 3'd2, '0, '0, '0);
    flush = 1'b1;
    #1;
    chk("fl_id_ready", VEC_W'(id_ready), 0);
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
    #1;
    chk("fl_valid", VEC_W'(ex_valid), 0);
    chk("fl_no_capture", VEC_W'(ex_opcode != 4'hA), 1);
    chk("fl_bubble", VEC_W'(bubble_count), 2);
    chk("fl_idle_ready", VEC_W'(id_ready), 1);
    tick();

    // Saturation: 253 more bubbles reach 255, 5 more stay there
    for (int i = 0; i < 253; i++) load_use_bubble();
    chk("sat_255", VEC_W'(bubble_count), 8'd255);
    for (int i = 0; i < 5; i++) load_use_bubble();
    chk("sat_hold", VEC_W'(bubble_count), 8'd255);

    // Asynchronous reset mid-cycle while holding
    present(4'hB, 13'h1FFF, 3'd0, 3'd0, 3'd7, '1, '1, '1);
    tick();
    chk("ar_pre_valid", VEC_W'(ex_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", VEC_W'(ex_valid), 0);
    chk("ar_opcode", VEC_W'(ex_opcode), 0);
    chk("ar_ctrl", VEC_W'(ex_ctrl), 0);
    chk("ar_dest", VEC_W'(ex_dest), 0);
    chk("ar_vdata_a", ex_vdata_a, 0);
    chk("ar_vdata_b", ex_vdata_b, 0);
    chk("ar_sdata", VEC_W'(ex_sdata), 0);
    chk("ar_bubble", VEC_W'(bubble_count), 0);
    chk("ar_id_ready", VEC_W'(id_ready), 0);
    id_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("ar_rel_ready", VEC_W'(id_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
